// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM encoding, frame command codes and widths.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int BYTE_W  = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CMD,
    SEND,
    WAIT,
    RECV,
    GAP
  } state_t;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  // Only a read-data frame expects the slave to answer with a byte.
  function automatic logic wants_response(input logic [1:0] code);
    logic resp;
    case (code)
      WR_ADDR, WR_DATA, RD_ADDR: resp = 1'b0;
      RD_DATA:                  resp = 1'b1;
      default:                  resp = 1'b0;
    endcase
    return resp;
  endfunction

endpackage

// File: rtl/spi_cmd_skid.sv
// One-entry command buffer that holds a frame word offered while the master is busy.
module spi_cmd_skid
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [FRAME_W-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic [FRAME_W-1:0] data
);

  logic               full_reg;
  logic [FRAME_W-1:0] data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (push) begin
      full_reg <= 1'b1;
      data_reg <= push_data;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  assign full = full_reg;
  assign data = data_reg;

endmodule

// File: rtl/spi_master.sv
// SPI frame master: START, CMD, 10 LSB-first frame bits, optional read-back byte, then GAP.
// Define SPI_MASTER_SKID_EN to accept one extra command while a frame is in flight.
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FRAME_W-1:0] cmd_data,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO,
  output logic [BYTE_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(BYTE_W - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic [BYTE_W-2:0]  shift_reg, shift_next;
  logic [BYTE_W-1:0]  rd_data_reg, rd_data_next;
  logic               rd_valid_reg, rd_valid_next;
  logic               ss_n_reg, ss_n_next;
  logic               mosi_reg, mosi_next;
  logic               accept;
  logic               direct;

  assign accept = cmd_valid && cmd_ready;

`ifdef SPI_MASTER_SKID_EN
  logic               buf_full;
  logic [FRAME_W-1:0] buf_data;
  logic               buf_push;
  logic               buf_pop;

  // A command seen in IDLE or in an empty-buffer GAP starts immediately; otherwise it is parked.
  assign direct    = accept && (state_reg == IDLE || state_reg == GAP);
  assign buf_push  = accept && !direct;
  assign buf_pop   = (state_reg == GAP) && buf_full;
  assign cmd_ready = !buf_full;

  spi_cmd_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (cmd_data),
    .pop       (buf_pop),
    .full      (buf_full),
    .data      (buf_data)
  );
`else
  assign direct    = accept;
  assign cmd_ready = (state_reg == IDLE);
`endif

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    frame_next    = frame_reg;
    shift_next    = shift_reg;
    rd_data_next  = rd_data_reg;
    rd_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (direct) begin
          state_next = START;
          frame_next = cmd_data;
        end
      end
      START: state_next = CMD;
      CMD: begin
        state_next = SEND;
        cnt_next   = '0;
      end
      SEND: begin
        if (cnt_reg == SEND_LAST) begin
          cnt_next = '0;
          if (!wants_response(frame_reg[FRAME_W-1 -: 2])) begin
            state_next = GAP;
          end else if (RD_LATENCY == 0) begin
            state_next = RECV;
          end else begin
            state_next = WAIT;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt_reg == LAT_LAST) begin
          cnt_next   = '0;
          state_next = RECV;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RECV: begin
        shift_next = {shift_reg[BYTE_W-3:0], MISO};
        if (cnt_reg == RECV_LAST) begin
          rd_data_next  = {shift_reg, MISO};
          rd_valid_next = 1'b1;
          cnt_next      = '0;
          state_next    = GAP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GAP: begin
`ifdef SPI_MASTER_SKID_EN
        if (buf_pop) begin
          state_next = START;
          frame_next = buf_data;
        end else if (direct) begin
          state_next = START;
          frame_next = cmd_data;
        end else begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase

    // Pin levels are decoded from the upcoming state so they change on the same edge as it.
    ss_n_next = (state_next == IDLE) || (state_next == GAP);
    mosi_next = 1'b0;
    if (state_next == CMD) begin
      mosi_next = frame_next[FRAME_W-1];
    end else if (state_next == SEND) begin
      mosi_next = frame_next[cnt_next];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      frame_reg    <= '0;
      shift_reg    <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      ss_n_reg     <= 1'b1;
      mosi_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      frame_reg    <= frame_next;
      shift_reg    <= shift_next;
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_valid_next;
      ss_n_reg     <= ss_n_next;
      mosi_reg     <= mosi_next;
    end
  end

  assign SS_n     = ss_n_reg;
  assign MOSI     = mosi_reg;
  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a per-cycle frame-timeline model with a toy slave/RAM, plus literal waveform pins.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cmd_valid_v = 2'b00;
  logic [9:0] cmd_data0 = '0;
  logic [9:0] cmd_data1 = '0;
  logic [1:0] miso_v = 2'b00;
  logic [1:0] ready_v, ss_v, mosi_v, rv_v, busy_v;
  logic [7:0] rd0, rd1;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  spi_master #(.RD_LATENCY(3)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid_v[0]),
    .cmd_ready (ready_v[0]),
    .cmd_data  (cmd_data0),
    .SS_n      (ss_v[0]),
    .MOSI      (mosi_v[0]),
    .MISO      (miso_v[0]),
    .rd_data   (rd0),
    .rd_valid  (rv_v[0]),
    .busy      (busy_v[0])
  );

  spi_master #(.RD_LATENCY(0)) u_dut_lat0 (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid_v[1]),
    .cmd_ready (ready_v[1]),
    .cmd_data  (cmd_data1),
    .SS_n      (ss_v[1]),
    .MOSI      (mosi_v[1]),
    .MISO      (miso_v[1]),
    .rd_data   (rd1),
    .rd_valid  (rv_v[1]),
    .busy      (busy_v[1])
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Accepted frames per instance: start edge, frame word, byte the slave answers with.
  int         fs [2][16];
  logic [9:0] fd [2][16];
  logic [7:0] fm [2][16];
  int         nf [2] = '{0, 0};
  logic [7:0] mem [2][256];
  logic [7:0] saddr [2] = '{8'h00, 8'h00};

  typedef struct packed {
    logic       ss;
    logic       mosi;
    logic       busy;
    logic       rv;
    logic       ready;
    logic [7:0] rd;
    logic       miso;
  } exp_t;

  function automatic int lat_of(int i);
    return (i == 0) ? 3 : 0;
  endfunction

  // Cycle index (from edge A) of the GAP cycle.
  function automatic int frame_len(int i, logic [9:0] f);
    return (f[9:8] == 2'b11) ? 20 + lat_of(i) : 12;
  endfunction

  function automatic exp_t model(int i, int c);
    exp_t x;
    int cur, k, len, r0, last;
    logic rd_frame;
    x.ss = 1'b1; x.mosi = 1'b0; x.busy = 1'b0; x.rv = 1'b0;
    x.ready = 1'b1; x.rd = 8'h00; x.miso = 1'b0;
    cur = -1;
    for (int j = 0; j < nf[i]; j++) begin
      if (fs[i][j] <= c) cur = j;
      if (fd[i][j][9:8] == 2'b11 && fs[i][j] + frame_len(i, fd[i][j]) <= c) x.rd = fm[i][j];
    end
    if (cur >= 0) begin
      k = c - fs[i][cur];
      len = frame_len(i, fd[i][cur]);
      rd_frame = (fd[i][cur][9:8] == 2'b11);
      if (k <= len) begin
        x.busy = 1'b1;
        x.ss = (k == len);
        if (k == 1) x.mosi = fd[i][cur][9];
        else if (k >= 2 && k <= 11) x.mosi = fd[i][cur][k-2];
        r0 = 12 + lat_of(i);
        if (rd_frame && k >= r0 && k < r0 + 8) x.miso = fm[i][cur][7-(k-r0)];
        x.rv = rd_frame && (k == len);
      end
    end
    if (nf[i] > 0) begin
      last = nf[i] - 1;
`ifdef SPI_MASTER_SKID_EN
      x.ready = !(fs[i][last] > c);
`else
      x.ready = !(c >= fs[i][last] && c <= fs[i][last] + frame_len(i, fd[i][last]));
`endif
    end
    return x;
  endfunction

  task automatic record(int i, int e, logic [9:0] f);
    int start, last;
    logic [7:0] ans;
    start = e;
    if (nf[i] > 0) begin
      last = nf[i] - 1;
      if (fs[i][last] + frame_len(i, fd[i][last]) + 1 > start)
        start = fs[i][last] + frame_len(i, fd[i][last]) + 1;
    end
    ans = 8'h00;
    case (f[9:8])
      2'b00: saddr[i] = f[7:0];
      2'b01: mem[i][saddr[i]] = f[7:0];
      2'b10: saddr[i] = f[7:0];
      default: ans = mem[i][saddr[i]];
    endcase
    fs[i][nf[i]] = start;
    fd[i][nf[i]] = f;
    fm[i][nf[i]] = ans;
    nf[i] = nf[i] + 1;
    $display("inst %0d: cmd %h accepted at edge %0d, frame starts at edge %0d", i, f, e, start);
  endtask

  task automatic check(int i, string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] cycle %0d: got %h, expected %h", name, i, cyc - 1, act, exp);
    end
  endtask

  task automatic wait_cycle(int c);
    do @(negedge clk); while (cyc - 1 < c);
  endtask

  task automatic send(int i, logic [9:0] f, output int e);
    int waited;
    waited = 0;
    e = -1;
    @(negedge clk);
    if (i == 0) cmd_data0 = f; else cmd_data1 = f;
    cmd_valid_v[i] = 1'b1;
    while (!ready_v[i]) begin
      @(negedge clk);
      waited++;
      if (waited > 300) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout[%0d]: cmd %h never accepted", i, f);
        cmd_valid_v[i] = 1'b0;
        return;
      end
    end
    @(posedge clk);
    e = cyc;
    record(i, e, f);
    #1 cmd_valid_v[i] = 1'b0;
  endtask

  task automatic expect_wave(int i, int e, logic [12:0] ss_exp, logic [12:0] mosi_exp);
    logic [12:0] ss_got, mosi_got;
    for (int k = 0; k < 13; k++) begin
      wait_cycle(e + k);
      ss_got[k] = ss_v[i];
      mosi_got[k] = mosi_v[i];
    end
    check(i, "wave_ss_n", 16'(ss_got), 16'(ss_exp));
    check(i, "wave_mosi", 16'(mosi_got), 16'(mosi_exp));
  endtask

  task automatic expect_read(int i, int e, int rv_at, logic [7:0] byte_exp);
    int first, pulses;
    logic [7:0] got;
    first = -1; pulses = 0; got = 8'h00;
    for (int k = 0; k <= rv_at + 2; k++) begin
      wait_cycle(e + k);
      if (rv_v[i]) begin
        pulses++;
        if (first < 0) begin
          first = k;
          got = (i == 0) ? rd0 : rd1;
        end
      end
    end
    check(i, "rv_cycle", 16'(first), 16'(rv_at));
    check(i, "rv_pulses", 16'(pulses), 16'd1);
    check(i, "rd_byte", 16'(got), 16'(byte_exp));
  endtask

  // Per-cycle comparison of both instances against the frame-timeline model.
  initial begin
    exp_t x;
    logic [7:0] rd_act;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        x = model(i, cyc - 1);
        rd_act = (i == 0) ? rd0 : rd1;
        check(i, "ss_n", 16'(ss_v[i]), 16'(x.ss));
        check(i, "mosi", 16'(mosi_v[i]), 16'(x.mosi));
        check(i, "busy", 16'(busy_v[i]), 16'(x.busy));
        check(i, "rd_valid", 16'(rv_v[i]), 16'(x.rv));
        check(i, "cmd_ready", 16'(ready_v[i]), 16'(x.ready));
        check(i, "rd_data", 16'(rd_act), 16'(x.rd));
      end
    end
  end

  // Slave side: MISO follows the model's answer byte, changed just after each rising edge.
  initial begin
    exp_t mx;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        mx = model(i, cyc - 1);
        miso_v[i] = mx.miso;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e1, e2, gap_cycles, guard;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) mem[i][a] = 8'h00;

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check(0, "ready_after_rst", 16'(ready_v[0]), 16'd1);
    check(1, "ready_after_rst", 16'(ready_v[1]), 16'd1);

    // Write-address frame waveform.
    send(0, 10'h0A5, e);
    expect_wave(0, e, 13'h1000, 13'h0294);

    // Store C3 at A5, then a read-data frame returns it.
    send(0, 10'h1C3, e);
    send(0, 10'h300, e);
    expect_read(0, e, 23, 8'hC3);

    // Write then read back through the slave RAM.
    send(0, 10'h010, e);
    send(0, 10'h177, e);
    send(0, 10'h210, e);
    send(0, 10'h300, e);
    expect_read(0, e, 23, 8'h77);

    // Back-to-back commands: count SS_n-high cycles between the two frames.
    gap_cycles = 0;
    fork
      begin
        send(0, 10'h1FF, e1);
        send(0, 10'h200, e2);
      end
      begin
        guard = 0;
        do begin @(negedge clk); guard++; end while (ss_v[0] && guard < 200);
        do begin @(negedge clk); guard++; end while (!ss_v[0] && guard < 200);
        while (ss_v[0] && guard < 200) begin
          gap_cycles++;
          @(negedge clk);
          guard++;
        end
      end
    join
`ifdef SPI_MASTER_SKID_EN
    check(0, "b2b_gap", 16'(gap_cycles), 16'd1);
`else
    check(0, "b2b_gap", 16'(gap_cycles), 16'd2);
`endif
    wait_cycle(e2 + 13);

    // Zero read latency: RECV follows the last SEND bit directly.
    send(1, 10'h15A, e);
    send(1, 10'h3FF, e);
    expect_read(1, e, 20, 8'h5A);

    // Asynchronous reset in the middle of SEND bit 5.
    send(0, 10'h0A5, e);
    wait_cycle(e + 7);
    check(0, "mosi_bit5", 16'(mosi_v[0]), 16'd1);
    #1 rst = 1'b1;
    nf[0] = 0;
    nf[1] = 0;
    #1;
    check(0, "rst_ss_n", 16'(ss_v[0]), 16'd1);
    check(0, "rst_mosi", 16'(mosi_v[0]), 16'd0);
    check(0, "rst_busy", 16'(busy_v[0]), 16'd0);
    check(0, "rst_rd_valid", 16'(rv_v[0]), 16'd0);
    check(0, "rst_rd_data", 16'(rd0), 16'h00);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    send(0, 10'h0A5, e);
    expect_wave(0, e, 13'h1000, 13'h0294);
    wait_cycle(e + 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 RD_LATENCY, default 3, SHALL set the idle clk cycles between the last MOSI bit and the first MISO bit of a read-data frame (legal range 0..15).
REQ-003 clk  input  1  system clock; all outputs are registered on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 cmd_valid  input  1  a command word is offered.
REQ-006 cmd_ready  output  1  a command word can be accepted.
REQ-007 cmd_data  input  10  frame word; [9:8] is the command code, [7:0] is the address or data.
REQ-008 SS_n  output  1  slave select, active low.
REQ-009 MOSI  output  1  serial data to the slave.
REQ-010 MISO  input  1  serial data from the slave.
REQ-011 rd_data  output  8  byte captured in a read-data frame.
REQ-012 rd_valid  output  1  one-cycle pulse; rd_data is valid.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; call that edge A.
REQ-015 The FSM SHALL use the states IDLE, START, CMD, SEND, WAIT, RECV and GAP.
REQ-016 IDLE SHALL drive SS_n=1 and MOSI=0, with cmd_ready=1, and SHALL go to START on acceptance.
REQ-017 START SHALL last from edge A to edge A+1, with SS_n=0 and MOSI=0.
REQ-018 CMD SHALL last from edge A+1 to edge A+2, with MOSI=cmd_data[9] (0 means write path, 1 means read path).
REQ-019 SEND SHALL last 10 cycles; in the cycle after edge A+2+i, MOSI SHALL equal cmd_data[i], for i=0..9 (LSB first).
REQ-020 After SEND, a frame with code 2'b11 SHALL go to WAIT; every other code SHALL go to GAP at edge A+12.
REQ-021 WAIT SHALL hold SS_n=0 and MOSI=0 for RD_LATENCY cycles; RD_LATENCY=0 SHALL skip WAIT.
REQ-022 RECV SHALL last 8 cycles, sample MISO on each closing edge, MSB first, into a shift register, and hold SS_n=0.
REQ-023 On the edge closing the 8th RECV cycle, rd_data SHALL load the byte and rd_valid SHALL go to 1 for exactly one cycle.
REQ-024 GAP SHALL drive SS_n=1 for exactly one cycle, then go to START if a command is pending, else to IDLE.
REQ-025 SS_n SHALL never go low without at least one preceding cycle of SS_n=1.
REQ-026 rd_data SHALL hold its value until the next read-data frame completes.
REQ-027 The master SHALL NOT enforce command ordering; it SHALL send whatever code is offered.
REQ-028 A cmd_valid that is not accepted SHALL be ignored, with no state change.

Reset
REQ-029 While rst is high, the block SHALL hold state=IDLE, SS_n=1, MOSI=0, rd_data=8'h00, rd_valid=0, busy=0, and all counters at 0, with no pending command.
REQ-030 Reset mid-frame SHALL abort the frame immediately (asynchronously), with no rd_valid pulse.
REQ-031 In the first cycle after rst deasserts, cmd_ready SHALL be 1.

Configuration
REQ-032 The macro SPI_MASTER_SKID_EN SHALL control a one-entry command buffer.
REQ-033 With SPI_MASTER_SKID_EN defined, a one-entry buffer SHALL accept one command while busy; cmd_ready SHALL equal !buffer_full, and the buffered command SHALL start in the cycle after GAP.
REQ-034 Without SPI_MASTER_SKID_EN, cmd_ready SHALL be high only in IDLE, and GAP SHALL always return to IDLE.

Structure
REQ-035 Package spi_pkg SHALL hold the state encoding, the command codes (WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11), FRAME_W=10 and BYTE_W=8.
REQ-036 The sub-module spi_cmd_skid SHALL implement the buffer and SHALL be instantiated only under SPI_MASTER_SKID_EN.

Verification
REQ-037 Write-address: send cmd_data=10'h0A5 -> SS_n low for 12 cycles; MOSI sequence 0,0,1,0,1,0,0,1,0,1,0,0; then SS_n high for 1 cycle.
REQ-038 Read-data: send 10'h300 with MISO driving 8'hC3, MSB first, from A+15 (RD_LATENCY=3) -> rd_data=8'hC3, rd_valid pulses after edge A+23.
REQ-039 Back-to-back: send 10'h1FF then 10'h200 with the macro defined -> second START exactly one GAP cycle after the first frame; without the macro, cmd_ready=0 until IDLE.
REQ-040 Reset during SEND bit 5 -> SS_n=1 and MOSI=0 immediately, rd_valid stays 0, and the next command runs a full frame.
REQ-041 RD_LATENCY=0 with 10'h3FF -> RECV starts directly after the last SEND bit, and rd_data matches the MISO pattern 8'h5A.
REQ-042 Run against the existing SPI slave and RAM: write address 8'h10, write data 8'h77, read address 8'h10, read data -> rd_data=8'h77.
